// File: rtl/bram18_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM18 between two clients.
// Optional: BRAM_ARB_WRITE_ACK_EN makes accepted writes return a response pulse.
module bram18_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_wen,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_wen,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_rdata
);

`ifdef BRAM_ARB_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  localparam int L = READ_LATENCY;

  logic          last;
  logic          gsel;
  logic          xfer;
  logic          gwen;
  logic          load;
  logic [L-1:0]  tvld;
  logic [L-1:0]  tid;

  // Client 1 wins when alone, or on a tie when client 0 went last.
  always_comb begin
    gsel       = req1_valid & (~req0_valid | ~last);
    req0_ready = req0_valid & ~gsel & ~reset;
    req1_ready = req1_valid & gsel & ~reset;
    xfer       = req0_ready | req1_ready;
    gwen       = gsel ? req1_wen : req0_wen;
    mem_addr   = gsel ? req1_addr : req0_addr;
    mem_data   = gsel ? req1_wdata : req0_wdata;
    mem_wen    = xfer & gwen;
    load       = xfer & (~gwen | WACK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (xfer) begin
      last <= gsel;
    end
  end

  // Tag pipe tracks which client owns mem_rdata L edges later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tvld <= '0;
      tid  <= '0;
    end else begin
      tvld[0] <= load;
      tid[0]  <= gsel;
      for (int k = 1; k < L; k++) begin
        tvld[k] <= tvld[k-1];
        tid[k]  <= tid[k-1];
      end
    end
  end

  assign rsp0_valid = tvld[L-1] & ~tid[L-1];
  assign rsp1_valid = tvld[L-1] & tid[L-1];
  assign rsp0_data  = mem_rdata;
  assign rsp1_data  = mem_rdata;

endmodule

// File: tb/tb_bram18_arbiter.sv
// Randomized bench for bram18_arbiter with a BRAM model and
// a transaction-level reference (grant rule, memory image, response queue).
module tb_bram18_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int L  = 3;

`ifdef BRAM_ARB_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 0, req1_valid = 0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = 0, req1_addr = 0;
  logic [DW-1:0] req0_wdata = 0, req1_wdata = 0;
  logic          req0_wen = 0, req1_wen = 0;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wen;
  logic [DW-1:0] mem_rdata;

  always #5 clock = ~clock;

  bram18_arbiter #(.AW(AW), .DW(DW), .READ_LATENCY(L)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_wen   (req0_wen),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_wen   (req1_wen),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata)
  );

  // BRAM: address captured at an edge, data valid L-1 edges later.
  logic [DW-1:0] ram [1024] = '{default: '0};
  logic [DW-1:0] rd  [L]    = '{default: '0};

  always @(posedge clock) begin
    if (mem_wen) ram[mem_addr] <= mem_data;
    rd[0] <= ram[mem_addr];
    for (int k = 1; k < L; k++) rd[k] <= rd[k-1];
  end

  assign mem_rdata = rd[L-1];

  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
    bit            isrd;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mm [1024] = '{default: '0};
  bit            last_m = 1'b1;
  int            win = 0;

  logic [1:0]    v = '0, w = '0;
  logic [AW-1:0] a [2] = '{default: '0};
  logic [DW-1:0] d [2] = '{default: '0};
  bit   [1:0]    acc = '0;
  int            wt = 0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (win %0d)",
               tag, got, exp, win);
    end
  endtask

  task automatic setr(input int i, input bit vv, input int ad,
                      input int dd, input bit ww);
    v[i] = vv;
    a[i] = ad[AW-1:0];
    d[i] = dd[DW-1:0];
    w[i] = ww;
  endtask

  // One clock: drive, check against model, then advance model at the edge.
  task automatic cyc(input bit r);
    bit   any, g, x, e0, e1;
    exp_t e;
    @(negedge clock);
    reset      = r;
    req0_valid = v[0]; req0_addr = a[0]; req0_wdata = d[0]; req0_wen = w[0];
    req1_valid = v[1]; req1_addr = a[1]; req1_wdata = d[1]; req1_wen = w[1];
    #1;
    if (r) begin
      q.delete();
      last_m = 1'b1;
    end
    any = v[0] | v[1];
    g   = (v[0] & v[1]) ? ~last_m : v[1];
    x   = any & ~r;
    chk("ready0", req0_ready, x & ~g);
    chk("ready1", req1_ready, x & g);
    chk("mem_wen", mem_wen, x & w[g]);
    chk("mem_addr", mem_addr, any ? a[g] : a[0]);
    if (x & w[g]) chk("mem_data", mem_data, d[g]);
    e0 = 0;
    e1 = 0;
    while (q.size() > 0 && q[0].due <= win) begin
      e = q.pop_front();
      if (e.id) e1 = 1; else e0 = 1;
      if (e.isrd && e.id)  chk("rsp1_data", rsp1_data, e.data);
      if (e.isrd && !e.id) chk("rsp0_data", rsp0_data, e.data);
    end
    chk("rsp0_valid", rsp0_valid, e0);
    chk("rsp1_valid", rsp1_valid, e1);
    acc = {req1_ready, req0_ready};
    @(posedge clock);
    if (x) begin
      last_m = g;
      if (!w[g] || ACK) q.push_back('{win + L, g, mm[a[g]], !w[g]});
      if (w[g]) mm[a[g]] = d[g];
    end
    win++;
  endtask

  task automatic gen(input int p0, input int p1);
    int p [2];
    p[0] = p0;
    p[1] = p1;
    for (int i = 0; i < 2; i++) begin
      if (!v[i] || acc[i]) begin
        v[i] = ($urandom_range(99) < p[i]);
        a[i] = ($urandom_range(9) == 0) ? AW'(10'h3FF)
                                        : AW'($urandom_range(15));
        d[i] = DW'($urandom);
        w[i] = 1'($urandom_range(1));
      end
    end
  endtask

  initial begin
    cyc(1);
    cyc(1);
    for (int k = 0; k < 8; k++) begin
      setr(0, 1, k, k + 'h10, 1);
      setr(1, 0, 0, 0, 0);
      cyc(0);
    end
    setr(0, 0, 0, 0, 0);
    cyc(0);
    setr(0, 1, 3, 0, 0);
    cyc(0);
    setr(0, 0, 0, 0, 0);
    repeat (L + 1) cyc(0);

    cyc(1);
    setr(0, 1, 1, 0, 0);
    setr(1, 1, 2, 0, 0);
    repeat (10) cyc(0);
    setr(0, 0, 0, 0, 0);
    setr(1, 0, 0, 0, 0);
    repeat (L + 1) cyc(0);

    acc = '0;
    repeat (30) begin
      gen(acc[0] ? 0 : 100, 100);
      cyc(0);
      wt = (v[1] && !acc[1]) ? wt + 1 : 0;
      chk("c1_wait_le1", 32'(wt > 1), 0);
    end
    setr(0, 0, 0, 0, 0);
    setr(1, 0, 0, 0, 0);
    repeat (L + 1) cyc(0);

    setr(0, 1, 5, 0, 0);
    cyc(0);
    setr(0, 0, 0, 0, 0);
    cyc(0);
    cyc(1);
    repeat (L + 1) cyc(0);
    setr(0, 1, 6, 0, 0);
    setr(1, 1, 7, 0, 0);
    repeat (4) cyc(0);
    setr(0, 0, 0, 0, 0);
    setr(1, 0, 0, 0, 0);
    repeat (L + 1) cyc(0);

    setr(1, 1, 'h3FF, 'hBEEF, 1);
    cyc(0);
    setr(1, 1, 'h3FF, 0, 0);
    cyc(0);
    setr(1, 0, 0, 0, 0);
    repeat (L + 1) cyc(0);

    acc = '0;
    repeat (500) begin
      gen(60, 60);
      if ($urandom_range(59) == 0) cyc(1);
      else cyc(0);
    end
    setr(0, 0, 0, 0, 0);
    setr(1, 0, 0, 0, 0);
    repeat (L + 1) cyc(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
